// File: rtl/iob_axi_reg_slice_if.sv
// AXI4 bundle (AW, W, B, AR, R) shared by both sides of the register slice.
// The master modport drives requests and the slave modport drives responses.
interface iob_axi_reg_slice_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [LEN_W-1:0]    awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [LEN_W-1:0]    arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/iob_axi_reg_slice.sv
// Full AXI4 register slice: a 2-entry skid buffer on each of AW, W, B, AR, R.
// Optional IOB_AXI_REG_SLICE_INIT_GATE_EN holds AW/W/AR ready low until DDR init is done.
module iob_axi_reg_slice_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         in_en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t       state_reg, state_next;
    logic         ready_reg;
    logic [W-1:0] out_reg, skid_reg;
    logic         accept, take, load_out, load_skid, move_skid;

    assign in_ready  = ready_reg & in_en;
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = out_reg;
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;

    always_comb begin
        state_next = state_reg;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        case (state_reg)
            EMPTY: if (accept) begin
                state_next = ONE;
                load_out   = 1'b1;
            end
            ONE: begin
                if (accept && !take) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (!accept && take) begin
                    state_next = EMPTY;
                end else if (accept && take) begin
                    load_out = 1'b1;
                end
            end
            FULL: if (take) begin
                state_next = ONE;
                move_skid  = 1'b1;
            end
            default: state_next = EMPTY;
        endcase
    end

    // ready is registered from the next state so no input-to-ready path exists
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= EMPTY;
            ready_reg <= 1'b0;
            out_reg   <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next != FULL);
            if (load_out)
                out_reg <= in_data;
            else if (move_skid)
                out_reg <= skid_reg;
            if (load_skid)
                skid_reg <= in_data;
        end
    end
endmodule

module iob_axi_reg_slice #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 init_done_i,
    iob_axi_reg_slice_if.slave   s_axi,
    iob_axi_reg_slice_if.master  m_axi
);
    localparam int A_W = ID_W + ADDR_W + LEN_W + 17;
    localparam int W_W = DATA_W + DATA_W / 8 + 1;
    localparam int B_W = ID_W + 2;
    localparam int R_W = ID_W + DATA_W + 3;

    logic           req_en;
    logic [A_W-1:0] aw_in, aw_out, ar_in, ar_out;
    logic [W_W-1:0] w_in, w_out;
    logic [B_W-1:0] b_in, b_out;
    logic [R_W-1:0] r_in, r_out;

`ifdef IOB_AXI_REG_SLICE_INIT_GATE_EN
    logic init_done_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            init_done_reg <= 1'b0;
        else
            init_done_reg <= init_done_i;
    end
    assign req_en = init_done_reg;
`else
    assign req_en = 1'b1;
`endif

    assign aw_in = {s_axi.awid, s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst,
                    s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos};
    assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst,
            m_axi.awlock, m_axi.awcache, m_axi.awprot, m_axi.awqos} = aw_out;
    assign ar_in = {s_axi.arid, s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst,
                    s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos};
    assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst,
            m_axi.arlock, m_axi.arcache, m_axi.arprot, m_axi.arqos} = ar_out;
    assign w_in = {s_axi.wdata, s_axi.wstrb, s_axi.wlast};
    assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast} = w_out;
    assign b_in = {m_axi.bid, m_axi.bresp};
    assign {s_axi.bid, s_axi.bresp} = b_out;
    assign r_in = {m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast};
    assign {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast} = r_out;

    iob_axi_reg_slice_skid #(.W(A_W)) u_aw (
        .clk(clk_i), .srst(rst_i), .in_en(req_en),
        .in_valid(s_axi.awvalid), .in_ready(s_axi.awready), .in_data(aw_in),
        .out_valid(m_axi.awvalid), .out_ready(m_axi.awready), .out_data(aw_out)
    );

    iob_axi_reg_slice_skid #(.W(W_W)) u_w (
        .clk(clk_i), .srst(rst_i), .in_en(req_en),
        .in_valid(s_axi.wvalid), .in_ready(s_axi.wready), .in_data(w_in),
        .out_valid(m_axi.wvalid), .out_ready(m_axi.wready), .out_data(w_out)
    );

    iob_axi_reg_slice_skid #(.W(A_W)) u_ar (
        .clk(clk_i), .srst(rst_i), .in_en(req_en),
        .in_valid(s_axi.arvalid), .in_ready(s_axi.arready), .in_data(ar_in),
        .out_valid(m_axi.arvalid), .out_ready(m_axi.arready), .out_data(ar_out)
    );

    // response channels are never gated so in-flight transactions can complete
    iob_axi_reg_slice_skid #(.W(B_W)) u_b (
        .clk(clk_i), .srst(rst_i), .in_en(1'b1),
        .in_valid(m_axi.bvalid), .in_ready(m_axi.bready), .in_data(b_in),
        .out_valid(s_axi.bvalid), .out_ready(s_axi.bready), .out_data(b_out)
    );

    iob_axi_reg_slice_skid #(.W(R_W)) u_r (
        .clk(clk_i), .srst(rst_i), .in_en(1'b1),
        .in_valid(m_axi.rvalid), .in_ready(m_axi.rready), .in_data(r_in),
        .out_valid(s_axi.rvalid), .out_ready(s_axi.rready), .out_data(r_out)
    );
endmodule

// File: tb/tb_iob_axi_reg_slice.sv
// Bench for iob_axi_reg_slice: per-channel FIFO scoreboard of capacity 2 with
// directed tests (reset, AR stream, W stall, R/B return, reset mid-burst) and a random phase.
module tb_iob_axi_reg_slice;
    logic clk = 1'b0;
    logic rst;
    logic init_done;
    always #5 clk = ~clk;

    iob_axi_reg_slice_if #(.ID_W(1), .ADDR_W(28), .DATA_W(32), .LEN_W(4)) s_if ();
    iob_axi_reg_slice_if #(.ID_W(1), .ADDR_W(28), .DATA_W(32), .LEN_W(4)) m_if ();

    iob_axi_reg_slice #(.ID_W(1), .ADDR_W(28), .DATA_W(32), .LEN_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .init_done_i(init_done), .s_axi(s_if), .m_axi(m_if)
    );

    // channel index: 0 AW, 1 W, 2 AR (s->m); 3 B, 4 R (m->s)
    logic [4:0]  in_v, out_r;
    logic [63:0] in_p [5];
    wire  [4:0]  in_rdy, out_v;
    wire  [63:0] out_p [5];
    string cname [5] = '{"aw", "w", "ar", "b", "r"};

    assign s_if.awvalid = in_v[0];
    assign {s_if.awid, s_if.awaddr, s_if.awlen, s_if.awsize, s_if.awburst, s_if.awlock,
            s_if.awcache, s_if.awprot, s_if.awqos} = in_p[0][49:0];
    assign m_if.awready = out_r[0];
    assign in_rdy[0] = s_if.awready;
    assign out_v[0]  = m_if.awvalid;
    assign out_p[0]  = {14'd0, m_if.awid, m_if.awaddr, m_if.awlen, m_if.awsize, m_if.awburst,
                        m_if.awlock, m_if.awcache, m_if.awprot, m_if.awqos};

    assign s_if.wvalid = in_v[1];
    assign {s_if.wdata, s_if.wstrb, s_if.wlast} = in_p[1][36:0];
    assign m_if.wready = out_r[1];
    assign in_rdy[1] = s_if.wready;
    assign out_v[1]  = m_if.wvalid;
    assign out_p[1]  = {27'd0, m_if.wdata, m_if.wstrb, m_if.wlast};

    assign s_if.arvalid = in_v[2];
    assign {s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst, s_if.arlock,
            s_if.arcache, s_if.arprot, s_if.arqos} = in_p[2][49:0];
    assign m_if.arready = out_r[2];
    assign in_rdy[2] = s_if.arready;
    assign out_v[2]  = m_if.arvalid;
    assign out_p[2]  = {14'd0, m_if.arid, m_if.araddr, m_if.arlen, m_if.arsize, m_if.arburst,
                        m_if.arlock, m_if.arcache, m_if.arprot, m_if.arqos};

    assign m_if.bvalid = in_v[3];
    assign {m_if.bid, m_if.bresp} = in_p[3][2:0];
    assign s_if.bready = out_r[3];
    assign in_rdy[3] = m_if.bready;
    assign out_v[3]  = s_if.bvalid;
    assign out_p[3]  = {61'd0, s_if.bid, s_if.bresp};

    assign m_if.rvalid = in_v[4];
    assign {m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast} = in_p[4][35:0];
    assign s_if.rready = out_r[4];
    assign in_rdy[4] = m_if.rready;
    assign out_v[4]  = s_if.rvalid;
    assign out_p[4]  = {28'd0, s_if.rid, s_if.rdata, s_if.rresp, s_if.rlast};

    function automatic logic [63:0] mask_of(input int ch);
        int w;
        case (ch)
            0, 2:    w = 50;
            1:       w = 37;
            3:       w = 3;
            default: w = 36;
        endcase
        return (64'd1 << w) - 64'd1;
    endfunction

    // reference: each channel is an in-order FIFO holding at most two beats,
    // output shows the oldest beat, input ready whenever fewer than two are held
    logic [63:0] sb_q [5][$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int since_rst = 0;
    int take_cnt [5] = '{0, 0, 0, 0, 0};
    int last_take [5] = '{0, 0, 0, 0, 0};
    bit gate_prev = 1'b0;
    bit saw_wready_low = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            for (int ch = 0; ch < 5; ch++) sb_q[ch].delete();
            since_rst = 0;
        end else begin
            since_rst++;
            for (int ch = 0; ch < 5; ch++) begin
                int  occ;
                bit  exp_rdy;
                occ = sb_q[ch].size();
                total++;
                if (out_v[ch] !== (occ > 0)) begin
                    bad++;
                    $display("FAIL %s_valid cyc=%0d: got %b want %b", cname[ch], cyc, out_v[ch], occ > 0);
                end
                if (out_v[ch] && occ > 0) begin
                    total++;
                    if (out_p[ch] !== sb_q[ch][0]) begin
                        bad++;
                        $display("FAIL %s_payload cyc=%0d: got %h want %h", cname[ch], cyc, out_p[ch], sb_q[ch][0]);
                    end
                end
                if (since_rst >= 2) begin
                    exp_rdy = (occ < 2);
`ifdef IOB_AXI_REG_SLICE_INIT_GATE_EN
                    if (ch < 3) exp_rdy = exp_rdy && gate_prev;
`endif
                    total++;
                    if (in_rdy[ch] !== exp_rdy) begin
                        bad++;
                        $display("FAIL %s_ready cyc=%0d: got %b want %b", cname[ch], cyc, in_rdy[ch], exp_rdy);
                    end
                    if (ch == 1 && !in_rdy[1]) saw_wready_low = 1'b1;
                end
                if (out_v[ch] && out_r[ch]) begin
                    if (occ > 0) void'(sb_q[ch].pop_front());
                    take_cnt[ch]++;
                    last_take[ch] = cyc;
                end
                if (in_v[ch] && in_rdy[ch]) sb_q[ch].push_back(in_p[ch] & mask_of(ch));
            end
        end
        gate_prev = init_done;
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic step_all(output logic [4:0] hs);
        @(negedge clk);
        hs = in_v & in_rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int ch, input logic [63:0] pay, output int acc_cyc);
        logic [4:0] hs;
        bit done;
        done = 1'b0;
        acc_cyc = -1;
        in_v[ch] = 1'b1;
        in_p[ch] = pay & mask_of(ch);
        for (int t = 0; t < 50 && !done; t++) begin
            step_all(hs);
            if (hs[ch]) begin
                done = 1'b1;
                acc_cyc = cyc;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_push_timeout: got no accept want accept within 50 cycles", cname[ch]);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [4:0] hs;
        int acc, first_acc, base, base_b;
        rst = 1'b1;
        init_done = 1'b1;
        in_v = '0;
        out_r = '0;
        for (int ch = 0; ch < 5; ch++) in_p[ch] = '0;

        // reset held three cycles: nothing valid, nothing ready, payloads zero
        repeat (3) begin
            @(negedge clk);
            check("rst_valids", {59'd0, out_v}, 64'd0);
            check("rst_readies", {59'd0, in_rdy}, 64'd0);
            check("rst_aw_payload", out_p[0], 64'd0);
            check("rst_r_payload", out_p[4], 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_release_cyc1", {59'd0, in_rdy}, 64'd0);
        @(negedge clk);
        check("ready_release_cyc2", {59'd0, in_rdy}, 64'h1f);
        @(posedge clk); #1;

        // AR: 8 back-to-back beats, downstream always ready
        out_r = 5'h1f;
        base = take_cnt[2];
        first_acc = 0;
        for (int k = 0; k < 8; k++) begin
            push_beat(2, rnd64(), acc);
            if (k == 0) first_acc = acc;
        end
        in_v[2] = 1'b0;
        repeat (3) step_all(hs);
        check("ar_count", 64'(take_cnt[2] - base), 64'd8);
        check("ar_last_take_cycle", 64'(last_take[2]), 64'(first_acc + 8));

        // W: 16-beat burst with a 5-cycle downstream stall in the middle
        base = take_cnt[1];
        saw_wready_low = 1'b0;
        fork
            begin
                for (int k = 0; k < 16; k++)
                    push_beat(1, {27'd0, 32'(k), 4'hf, (k == 15)}, acc);
                in_v[1] = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_r[1] = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_r[1] = 1'b1;
            end
        join
        repeat (4) step_all(hs);
        check("w_count", 64'(take_cnt[1] - base), 64'd16);
        check("w_ready_dropped", {63'd0, saw_wready_low}, 64'd1);

        // R burst of 4 with rready toggling, plus one B response
        base = take_cnt[4];
        base_b = take_cnt[3];
        fork
            begin
                for (int k = 0; k < 4; k++)
                    push_beat(4, {28'd0, 1'b1, $urandom, 2'b00, (k == 3)}, acc);
                in_v[4] = 1'b0;
            end
            begin
                for (int t = 0; t < 16; t++) begin
                    out_r[4] = (t % 2 == 0);
                    @(posedge clk); #1;
                end
                out_r[4] = 1'b1;
            end
            begin
                push_beat(3, {61'd0, 1'b1, 2'b00}, acc);
                in_v[3] = 1'b0;
            end
        join
        repeat (3) step_all(hs);
        check("r_count", 64'(take_cnt[4] - base), 64'd4);
        check("b_count", 64'(take_cnt[3] - base_b), 64'd1);

        // reset with W holding two beats: everything buffered is dropped
        out_r[1] = 1'b0;
        push_beat(1, rnd64(), acc);
        push_beat(1, rnd64(), acc);
        in_v[1] = 1'b0;
        @(negedge clk);
        check("w_full_ready", {63'd0, in_rdy[1]}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("w_valid_after_rst", {63'd0, out_v[1]}, 64'd0);
        rst = 1'b0;
        out_r = 5'h1f;
        base = take_cnt[1];
        repeat (4) step_all(hs);
        check("w_no_stale_after_rst", 64'(take_cnt[1] - base), 64'd0);

`ifdef IOB_AXI_REG_SLICE_INIT_GATE_EN
        // AW held off until init_done, then accepted within two cycles
        init_done = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        in_v[0] = 1'b1;
        in_p[0] = rnd64() & mask_of(0);
        acc = 0;
        for (int t = 0; t < 5; t++) begin
            step_all(hs);
            if (hs[0]) acc = 1;
        end
        check("gate_aw_held", 64'(acc), 64'd0);
        init_done = 1'b1;
        for (int t = 0; t < 2 && acc == 0; t++) begin
            step_all(hs);
            if (hs[0]) acc = 1;
        end
        check("gate_aw_accept", 64'(acc), 64'd1);
        in_v[0] = 1'b0;
        repeat (3) step_all(hs);
`endif

        // random traffic on all five channels
        hs = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < 5; ch++) begin
                if (!in_v[ch] || hs[ch]) begin
                    in_v[ch] = ($urandom_range(0, 9) < 6);
                    in_p[ch] = rnd64() & mask_of(ch);
                end
                out_r[ch] = ($urandom_range(0, 9) < 7);
            end
            step_all(hs);
        end
        in_v = '0;
        out_r = 5'h1f;
        repeat (5) step_all(hs);
        for (int ch = 0; ch < 5; ch++)
            check({cname[ch], "_drained"}, 64'(sb_q[ch].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
